doc_monitor_avmm_cmd_master: RTL



---
 rtl/doc_monitor_avmm_pkg.sv | 28 ++
 rtl/doc_monitor_avmm_wdog.sv | 28 ++
 rtl/doc_monitor_avmm_cmd_master.sv | 136 +++++++++++++
 3 files changed

// File: rtl/doc_monitor_avmm_pkg.sv
// Shared types and constants for the Avalon-MM command master.
// FSM states, default widths and the legal read-latency range.
package doc_monitor_avmm_pkg;

  localparam int unsigned DEF_ADDR_W = 2;
  localparam int unsigned DEF_DATA_W = 32;

  localparam int unsigned RD_LAT_MIN = 1;
  localparam int unsigned RD_LAT_MAX = 4;
  localparam int unsigned LAT_W      = 2;

  localparam int unsigned STATE_W = 3;
  typedef logic [STATE_W-1:0] state_t;

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] WR   = 3'd1;
  localparam logic [2:0] RD   = 3'd2;
  localparam logic [2:0] LAT  = 3'd3;
  localparam logic [2:0] RSP  = 3'd4;

  // Out-of-range latencies are clamped so the counter can never wrap.
  function automatic logic [LAT_W-1:0] lat_load(input int unsigned rl);
    int unsigned r;
    r = (rl < RD_LAT_MIN) ? RD_LAT_MIN : ((rl > RD_LAT_MAX) ? RD_LAT_MAX : rl);
    return LAT_W'(r - 1);
  endfunction

endpackage

// File: rtl/doc_monitor_avmm_wdog.sv
// Waitrequest watchdog: counts stalled cycles while a transfer is outstanding.
// Instantiated only when DOC_MONITOR_AVMM_TIMEOUT_EN is defined.
module doc_monitor_avmm_wdog #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic active,
  input  logic stall,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q;

  // Fires in the TIMEOUT_CYCLES-th consecutive stalled cycle of a transfer.
  assign expired = active && stall && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset || !active) begin
      cnt_q <= '0;
    end else if (stall && !expired) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/doc_monitor_avmm_cmd_master.sv
// Single-outstanding Avalon-MM initiator for PIO-style slaves with fixed read latency.
// Optional waitrequest timeout enabled by defining DOC_MONITOR_AVMM_TIMEOUT_EN.
module doc_monitor_avmm_cmd_master
  import doc_monitor_avmm_pkg::*;
#(
  parameter int unsigned ADDR_W         = DEF_ADDR_W,
  parameter int unsigned DATA_W         = DEF_DATA_W,
  parameter int unsigned READ_LATENCY   = 1,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_address,
  input  logic [DATA_W-1:0] cmd_writedata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_readdata,
  output logic              rsp_error,
  output logic              busy,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [DATA_W-1:0] avm_writedata,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_waitrequest
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic              err_q, err_d;
  logic              expired;

`ifdef DOC_MONITOR_AVMM_TIMEOUT_EN
  doc_monitor_avmm_wdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdog (
    .clk    (clk),
    .reset  (reset),
    .active ((state_q == WR) || (state_q == RD)),
    .stall  (avm_waitrequest),
    .expired(expired)
  );
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign expired        = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    lat_d   = lat_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        // A write-timeout error lives for exactly one IDLE cycle.
        err_d = 1'b0;
        if (cmd_valid) begin
          addr_d  = cmd_address;
          wdata_d = cmd_writedata;
          state_d = cmd_write ? WR : RD;
        end
      end
      WR: begin
        if (!avm_waitrequest) begin
          state_d = IDLE;
        end else if (expired) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
      end
      RD: begin
        if (!avm_waitrequest) begin
          state_d = LAT;
          lat_d   = lat_load(READ_LATENCY);
        end else if (expired) begin
          state_d = RSP;
          rdata_d = '0;
          err_d   = 1'b1;
        end
      end
      LAT: begin
        if (lat_q == '0) begin
          rdata_d = avm_readdata;
          state_d = RSP;
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end
      RSP: begin
        if (rsp_ready) begin
          state_d = IDLE;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      lat_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      lat_q   <= lat_d;
      err_q   <= err_d;
    end
  end

  assign cmd_ready     = (state_q == IDLE);
  assign busy          = (state_q != IDLE);
  assign avm_read      = (state_q == RD);
  assign avm_write     = (state_q == WR);
  assign avm_address   = addr_q;
  assign avm_writedata = wdata_q;
  assign rsp_valid     = (state_q == RSP);
  assign rsp_readdata  = rdata_q;
  assign rsp_error     = err_q;

endmodule
